// File: rtl/a2d_spi_slv.sv
// SPI slave front end for an A2D channel table: receives 16-bit commands, returns the
// previously commanded channel's 12-bit value. Define A2D_SLV_AUTOINC_EN to auto-increment read entries.
module a2d_spi_slv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [11:0] wr_data,
  output logic        cmd_vld,
  output logic [2:0]  cmd_chnnl,
  output logic        frm_err
);

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  logic        ss_s1_q, ss_s2_q, ss_h_q;
  logic        sclk_s1_q, sclk_s2_q, sclk_h_q;
  logic        mosi_s1_q, mosi_s2_q, mosi_h_q;
  logic        state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] rx_shft_q, rx_shft_d;
  logic [15:0] tx_shft_q, tx_shft_d;
  logic        cmd_vld_q, cmd_vld_d;
  logic        frm_err_q, frm_err_d;
  logic [2:0]  cmd_chnnl_q, cmd_chnnl_d;
  logic [2:0]  last_chnnl_q, last_chnnl_d;
  logic [11:0] tbl_q [8];
  logic [11:0] tbl_d [8];

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  assign ss_fall   =  ss_h_q   & ~ss_s2_q;
  assign ss_rise   = ~ss_h_q   &  ss_s2_q;
  assign sclk_rise = ~sclk_h_q &  sclk_s2_q;
  assign sclk_fall =  sclk_h_q & ~sclk_s2_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shft_d    = rx_shft_q;
    tx_shft_d    = tx_shft_q;
    cmd_vld_d    = 1'b0;
    frm_err_d    = 1'b0;
    cmd_chnnl_d  = cmd_chnnl_q;
    last_chnnl_d = last_chnnl_q;
    tbl_d        = tbl_q;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = SHIFT;
          tx_shft_d = {4'h0, tbl_q[last_chnnl_q]};
          bit_cnt_d = 5'd0;
        end
      end
      SHIFT: begin
        // SS_n rise outranks any SCLK edge seen in the same cycle
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_q == 5'd16) begin
            cmd_vld_d    = 1'b1;
            cmd_chnnl_d  = rx_shft_q[13:11];
            last_chnnl_d = rx_shft_q[13:11];
`ifdef A2D_SLV_AUTOINC_EN
            tbl_d[last_chnnl_q] = tbl_q[last_chnnl_q] + 12'd1;
`endif
          end else begin
            frm_err_d = 1'b1;
          end
        end else begin
          // MOSI is held for a whole SCLK phase, so the history copy is already stable here
          if (sclk_rise) begin
            rx_shft_d = {rx_shft_q[14:0], mosi_h_q};
            if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
          end
          if (sclk_fall) tx_shft_d = {tx_shft_q[14:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    // host write is applied last so it wins over the increment
    if (wr_en) tbl_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_s1_q      <= 1'b1;
      ss_s2_q      <= 1'b1;
      ss_h_q       <= 1'b1;
      sclk_s1_q    <= 1'b0;
      sclk_s2_q    <= 1'b0;
      sclk_h_q     <= 1'b0;
      mosi_s1_q    <= 1'b0;
      mosi_s2_q    <= 1'b0;
      mosi_h_q     <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= 5'd0;
      rx_shft_q    <= 16'h0000;
      tx_shft_q    <= 16'h0000;
      cmd_vld_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      cmd_chnnl_q  <= 3'b000;
      last_chnnl_q <= 3'b000;
      for (int i = 0; i < 8; i++) tbl_q[i] <= 12'h000;
    end else begin
      ss_s1_q      <= SS_n;
      ss_s2_q      <= ss_s1_q;
      ss_h_q       <= ss_s2_q;
      sclk_s1_q    <= SCLK;
      sclk_s2_q    <= sclk_s1_q;
      sclk_h_q     <= sclk_s2_q;
      mosi_s1_q    <= MOSI;
      mosi_s2_q    <= mosi_s1_q;
      mosi_h_q     <= mosi_s2_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shft_q    <= rx_shft_d;
      tx_shft_q    <= tx_shft_d;
      cmd_vld_q    <= cmd_vld_d;
      frm_err_q    <= frm_err_d;
      cmd_chnnl_q  <= cmd_chnnl_d;
      last_chnnl_q <= last_chnnl_d;
      for (int i = 0; i < 8; i++) tbl_q[i] <= tbl_d[i];
    end
  end

  assign MISO      = (state_q == SHIFT) & tx_shft_q[15];
  assign cmd_vld   = cmd_vld_q;
  assign frm_err   = frm_err_q;
  assign cmd_chnnl = cmd_chnnl_q;

endmodule
